// File: rtl/sfm_pkg.sv
// Shared types for the softmax add/mul datapath: element formats, unit
// operation selects and the add/mul issuer state encoding.
package sfm_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [0:0] {
    ADD = 1'b0,
    MUL = 1'b1
  } operation_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE_ADD = 2'd1,
    ISSUE_MUL = 2'd2
  } issuer_state_t;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32'd32;
      FP64:    return 32'd64;
      FP16:    return 32'd16;
      FP8:     return 32'd8;
      FP16ALT: return 32'd16;
      default: return 32'd16;
    endcase
  endfunction

endpackage

// File: rtl/sfm_credit_counter.sv
// Per-operation in-flight beat counter: counts issued beats, gives a credit back
// on each observed result handshake, and flags when no further beat may issue.
module sfm_credit_counter #(
  parameter  int unsigned MAX = 4,
  localparam int unsigned CW  = $clog2(MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  logic [CW-1:0] r_count;
  logic          w_inc;
  logic          w_dec;

  // Saturate at both ends; a spurious return at zero is dropped.
  assign w_inc = inc_i && (r_count < CW'(MAX));
  assign w_dec = dec_i && (r_count != {CW{1'b0}});

  // Outstanding count update; clear shares priority with reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_count <= {CW{1'b0}};
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count_o = r_count;
  assign full_o  = (r_count >= CW'(MAX));

endmodule

// File: rtl/sfm_addmul_issuer.sv
// Add/mul issuer: arbitrates the add and mul request streams onto the shared
// add/mul unit in bounded bursts, with per-operation in-flight credit limits.
module sfm_addmul_issuer
  import sfm_pkg::*;
#(
  parameter  fp_format_e  FPFORMAT        = FP16ALT,
  parameter  int unsigned VECT_WIDTH      = 1,
  parameter  int unsigned BURST_LEN       = 4,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned WIDTH           = fp_width(FPFORMAT),
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        enable_i,
  input  logic                        add_req_valid_i,
  output logic                        add_req_ready_o,
  input  logic [VECT_WIDTH-1:0]       add_req_strb_i,
  input  logic [VECT_WIDTH*WIDTH-1:0] add_req_vect_i,
  input  logic                        add_req_mod_i,
  input  logic                        mul_req_valid_i,
  output logic                        mul_req_ready_o,
  input  logic [VECT_WIDTH-1:0]       mul_req_strb_i,
  input  logic [VECT_WIDTH*WIDTH-1:0] mul_req_vect_i,
  input  logic                        mul_req_mod_i,
  output operation_t                  operation_o,
  output logic                        op_mod_add_o,
  output logic                        op_mod_mul_o,
  output logic                        add_valid_o,
  input  logic                        add_ready_i,
  output logic [VECT_WIDTH-1:0]       add_strb_o,
  output logic [VECT_WIDTH*WIDTH-1:0] add_vect_o,
  output logic                        mul_valid_o,
  input  logic                        mul_ready_i,
  output logic [VECT_WIDTH-1:0]       mul_strb_o,
  output logic [VECT_WIDTH*WIDTH-1:0] mul_vect_o,
  input  logic                        add_res_valid_i,
  input  logic                        add_res_ready_i,
  input  logic                        mul_res_valid_i,
  input  logic                        mul_res_ready_i,
  output logic [CW-1:0]               add_outstanding_o,
  output logic [CW-1:0]               mul_outstanding_o,
  output logic                        busy_o
);

  localparam int unsigned BW = $clog2(BURST_LEN + 1);

  issuer_state_t r_state;
  operation_t    r_operation;
  logic          r_last_mul;
  logic [BW-1:0] r_beat_cnt;

  logic          w_add_full;
  logic          w_mul_full;
  logic [CW-1:0] w_add_count;
  logic [CW-1:0] w_mul_count;
  logic          w_add_open;
  logic          w_mul_open;
  logic          w_add_beat;
  logic          w_mul_beat;
  logic          w_add_ret;
  logic          w_mul_ret;
  logic [BW:0]   w_beat_sum;
  logic          w_burst_done;
  logic [BW-1:0] w_beat_cnt_nxt;

  // Credit checks use the registered count, so a same-cycle return cannot unblock issue.
  assign w_add_open = (r_state == ISSUE_ADD) && !rst_i && enable_i && !w_add_full;
  assign w_mul_open = (r_state == ISSUE_MUL) && !rst_i && enable_i && !w_mul_full;

  assign add_valid_o     = w_add_open && add_req_valid_i;
  assign add_req_ready_o = w_add_open && add_ready_i;
  assign mul_valid_o     = w_mul_open && mul_req_valid_i;
  assign mul_req_ready_o = w_mul_open && mul_ready_i;

  assign add_strb_o   = add_req_strb_i;
  assign add_vect_o   = add_req_vect_i;
  assign op_mod_add_o = add_req_mod_i;
  assign mul_strb_o   = mul_req_strb_i;
  assign mul_vect_o   = mul_req_vect_i;
  assign op_mod_mul_o = mul_req_mod_i;

  assign w_add_beat = add_valid_o && add_ready_i;
  assign w_mul_beat = mul_valid_o && mul_ready_i;
  assign w_add_ret  = add_res_valid_i && add_res_ready_i;
  assign w_mul_ret  = mul_res_valid_i && mul_res_ready_i;

  // Burst length includes the beat completing this cycle so a switch adds no idle gap.
  assign w_beat_sum     = {1'b0, r_beat_cnt} + {{BW{1'b0}}, (w_add_beat || w_mul_beat)};
  assign w_burst_done   = (w_beat_sum >= (BW + 1)'(BURST_LEN));
  assign w_beat_cnt_nxt = w_burst_done ? BW'(BURST_LEN) : w_beat_sum[BW-1:0];

  // Issue FSM with round-robin arbitration and registered operation select.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state     <= IDLE;
      r_operation <= ADD;
      r_last_mul  <= 1'b1;
      r_beat_cnt  <= {BW{1'b0}};
    end else if (enable_i) begin
      case (r_state)
        IDLE: begin
          if (add_req_valid_i && (!mul_req_valid_i || r_last_mul)) begin
            r_state     <= ISSUE_ADD;
            r_operation <= ADD;
            r_last_mul  <= 1'b0;
            r_beat_cnt  <= {BW{1'b0}};
          end else if (mul_req_valid_i) begin
            r_state     <= ISSUE_MUL;
            r_operation <= MUL;
            r_last_mul  <= 1'b1;
            r_beat_cnt  <= {BW{1'b0}};
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE_ADD: begin
          if ((w_burst_done || !add_req_valid_i) && mul_req_valid_i) begin
            r_state     <= ISSUE_MUL;
            r_operation <= MUL;
            r_last_mul  <= 1'b1;
            r_beat_cnt  <= {BW{1'b0}};
          end else if (!add_req_valid_i) begin
            r_state     <= IDLE;
            r_operation <= ADD;
            r_beat_cnt  <= {BW{1'b0}};
          end else begin
            r_beat_cnt <= w_beat_cnt_nxt;
          end
        end
        ISSUE_MUL: begin
          if ((w_burst_done || !mul_req_valid_i) && add_req_valid_i) begin
            r_state     <= ISSUE_ADD;
            r_operation <= ADD;
            r_last_mul  <= 1'b0;
            r_beat_cnt  <= {BW{1'b0}};
          end else if (!mul_req_valid_i) begin
            r_state     <= IDLE;
            r_operation <= ADD;
            r_beat_cnt  <= {BW{1'b0}};
          end else begin
            r_beat_cnt <= w_beat_cnt_nxt;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_operation <= ADD;
          r_beat_cnt  <= {BW{1'b0}};
        end
      endcase
    end
  end

  sfm_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) i_add_credit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .inc_i   (w_add_beat),
    .dec_i   (w_add_ret),
    .count_o (w_add_count),
    .full_o  (w_add_full)
  );

  sfm_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) i_mul_credit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .inc_i   (w_mul_beat),
    .dec_i   (w_mul_ret),
    .count_o (w_mul_count),
    .full_o  (w_mul_full)
  );

  assign operation_o       = r_operation;
  assign add_outstanding_o = w_add_count;
  assign mul_outstanding_o = w_mul_count;
  assign busy_o            = (r_state != IDLE) || (w_add_count != {CW{1'b0}})
                          || (w_mul_count != {CW{1'b0}});

endmodule

// File: tb/tb_sfm_addmul_issuer.sv
// Self-checking bench for sfm_addmul_issuer: directed scenarios plus a random
// phase, all checked cycle by cycle against a behavioural reference model.
module tb_sfm_addmul_issuer;
  import sfm_pkg::*;

  localparam int unsigned VW = 1;
  localparam int unsigned W  = 16;
  localparam int unsigned BL = 4;
  localparam int unsigned MO = 4;
  localparam int unsigned CW = $clog2(MO + 1);

  logic clk_i = 1'b0;
  logic rst_i, clear_i, enable_i;
  logic add_req_valid_i, add_req_ready_o, add_req_mod_i;
  logic mul_req_valid_i, mul_req_ready_o, mul_req_mod_i;
  logic [VW-1:0] add_req_strb_i, mul_req_strb_i, add_strb_o, mul_strb_o;
  logic [VW*W-1:0] add_req_vect_i, mul_req_vect_i, add_vect_o, mul_vect_o;
  operation_t operation_o;
  logic op_mod_add_o, op_mod_mul_o;
  logic add_valid_o, add_ready_i, mul_valid_o, mul_ready_i;
  logic add_res_valid_i, add_res_ready_i, mul_res_valid_i, mul_res_ready_i;
  logic [CW-1:0] add_outstanding_o, mul_outstanding_o;
  logic busy_o;

  always #5 clk_i = ~clk_i;

  sfm_addmul_issuer #(
    .FPFORMAT(FP16ALT), .VECT_WIDTH(VW), .BURST_LEN(BL), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
    .add_req_valid_i(add_req_valid_i), .add_req_ready_o(add_req_ready_o),
    .add_req_strb_i(add_req_strb_i), .add_req_vect_i(add_req_vect_i), .add_req_mod_i(add_req_mod_i),
    .mul_req_valid_i(mul_req_valid_i), .mul_req_ready_o(mul_req_ready_o),
    .mul_req_strb_i(mul_req_strb_i), .mul_req_vect_i(mul_req_vect_i), .mul_req_mod_i(mul_req_mod_i),
    .operation_o(operation_o), .op_mod_add_o(op_mod_add_o), .op_mod_mul_o(op_mod_mul_o),
    .add_valid_o(add_valid_o), .add_ready_i(add_ready_i), .add_strb_o(add_strb_o), .add_vect_o(add_vect_o),
    .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_i), .mul_strb_o(mul_strb_o), .mul_vect_o(mul_vect_o),
    .add_res_valid_i(add_res_valid_i), .add_res_ready_i(add_res_ready_i),
    .mul_res_valid_i(mul_res_valid_i), .mul_res_ready_i(mul_res_ready_i),
    .add_outstanding_o(add_outstanding_o), .mul_outstanding_o(mul_outstanding_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = serving add, 2 = serving mul.
  int m_state = 0;
  int m_burst = 0;
  bit m_last_mul = 1'b1;
  int m_out_add = 0;
  int m_out_mul = 0;
  int cyc = 0;
  bit [2:0] add_hist = 3'b000;
  bit [2:0] mul_hist = 3'b000;
  int add_cyc_q[$];
  int mul_cyc_q[$];
  bit seq_q[$];
  bit auto_ret = 1'b0;

  always @(negedge clk_i) begin : mon
    bit e_add_v, e_add_r, e_mul_v, e_mul_r, b_add, b_mul, cur_v, oth_v, d_add, d_mul;
    int served;
    e_add_v = !rst_i && m_state == 1 && enable_i && add_req_valid_i && m_out_add < MO;
    e_add_r = !rst_i && m_state == 1 && enable_i && add_ready_i && m_out_add < MO;
    e_mul_v = !rst_i && m_state == 2 && enable_i && mul_req_valid_i && m_out_mul < MO;
    e_mul_r = !rst_i && m_state == 2 && enable_i && mul_ready_i && m_out_mul < MO;
    check_eq("add_valid", 64'(add_valid_o), 64'(e_add_v));
    check_eq("add_req_ready", 64'(add_req_ready_o), 64'(e_add_r));
    check_eq("mul_valid", 64'(mul_valid_o), 64'(e_mul_v));
    check_eq("mul_req_ready", 64'(mul_req_ready_o), 64'(e_mul_r));
    check_eq("operation", 64'(operation_o), 64'(m_state == 2));
    check_eq("add_outstanding", 64'(add_outstanding_o), 64'(m_out_add));
    check_eq("mul_outstanding", 64'(mul_outstanding_o), 64'(m_out_mul));
    check_eq("busy", 64'(busy_o), 64'(m_state != 0 || m_out_add != 0 || m_out_mul != 0));
    check_eq("add_fwd", 64'({add_strb_o, add_vect_o, op_mod_add_o}),
             64'({add_req_strb_i, add_req_vect_i, add_req_mod_i}));
    check_eq("mul_fwd", 64'({mul_strb_o, mul_vect_o, op_mod_mul_o}),
             64'({mul_req_strb_i, mul_req_vect_i, mul_req_mod_i}));
    d_add = add_valid_o && add_ready_i;
    d_mul = mul_valid_o && mul_ready_i;
    if (d_add) begin add_cyc_q.push_back(cyc); seq_q.push_back(1'b0); end
    if (d_mul) begin mul_cyc_q.push_back(cyc); seq_q.push_back(1'b1); end
    b_add = e_add_v && add_ready_i;
    b_mul = e_mul_v && mul_ready_i;
    if (rst_i || clear_i) begin
      m_state = 0; m_burst = 0; m_last_mul = 1'b1; m_out_add = 0; m_out_mul = 0;
    end else begin
      m_out_add = m_out_add + int'(b_add) - ((add_res_valid_i && add_res_ready_i && m_out_add > 0) ? 1 : 0);
      m_out_mul = m_out_mul + int'(b_mul) - ((mul_res_valid_i && mul_res_ready_i && m_out_mul > 0) ? 1 : 0);
      if (enable_i) begin
        if (m_state == 0) begin
          if (add_req_valid_i && (!mul_req_valid_i || m_last_mul)) begin
            m_state = 1; m_last_mul = 1'b0; m_burst = 0;
          end else if (mul_req_valid_i) begin
            m_state = 2; m_last_mul = 1'b1; m_burst = 0;
          end
        end else begin
          cur_v  = (m_state == 1) ? add_req_valid_i : mul_req_valid_i;
          oth_v  = (m_state == 1) ? mul_req_valid_i : add_req_valid_i;
          served = m_burst + int'(b_add || b_mul);
          if ((served >= BL || !cur_v) && oth_v) begin
            m_state = 3 - m_state; m_last_mul = (m_state == 2); m_burst = 0;
          end else if (!cur_v) begin
            m_state = 0; m_burst = 0;
          end else begin
            m_burst = served;
          end
        end
      end
    end
    add_hist = {add_hist[1:0], d_add};
    mul_hist = {mul_hist[1:0], d_mul};
    cyc++;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      if (auto_ret) begin
        add_res_valid_i = add_hist[1]; add_res_ready_i = 1'b1;
        mul_res_valid_i = mul_hist[1]; mul_res_ready_i = 1'b1;
      end
    end
  endtask

  task automatic idle_inputs();
    clear_i = 1'b0; enable_i = 1'b1;
    add_req_valid_i = 1'b0; add_req_mod_i = 1'b0; add_req_strb_i = '1; add_req_vect_i = '0;
    mul_req_valid_i = 1'b0; mul_req_mod_i = 1'b1; mul_req_strb_i = '1; mul_req_vect_i = '0;
    add_ready_i = 1'b0; mul_ready_i = 1'b0;
    add_res_valid_i = 1'b0; add_res_ready_i = 1'b0; mul_res_valid_i = 1'b0; mul_res_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    auto_ret = 1'b0;
    idle_inputs();
    rst_i = 1'b1;
    step(2);
    rst_i = 1'b0;
    add_cyc_q.delete(); mul_cyc_q.delete(); seq_q.delete();
  endtask

  initial begin : drv
    int s;
    idle_inputs();
    rst_i = 1'b1;
    step(3);
    check_eq("rst_outputs", 64'({add_valid_o, mul_valid_o, add_req_ready_o, mul_req_ready_o}), 64'(0));
    rst_i = 1'b0;
    step(1);
    check_eq("rst_op", 64'(operation_o), 64'(ADD));
    check_eq("rst_counts", 64'({add_outstanding_o, mul_outstanding_o, busy_o}), 64'(0));

    // Add stream alone: 6 consecutive beats after one idle cycle.
    do_reset();
    auto_ret = 1'b1; add_ready_i = 1'b1; mul_ready_i = 1'b1;
    s = cyc; add_req_valid_i = 1'b1;
    for (int i = 0; i < 40 && add_cyc_q.size() < 6; i++) begin
      step(1); add_req_vect_i = (VW * W)'($urandom);
    end
    add_req_valid_i = 1'b0;
    step(6);
    check_eq("solo_beats", 64'(add_cyc_q.size()), 64'(6));
    if (add_cyc_q.size() == 6) begin
      check_eq("solo_first", 64'(add_cyc_q[0]), 64'(s + 1));
      check_eq("solo_last", 64'(add_cyc_q[5]), 64'(s + 6));
    end
    check_eq("solo_no_mul", 64'(mul_cyc_q.size()), 64'(0));

    // Both streams saturated: alternating bursts of BL, add first.
    do_reset();
    auto_ret = 1'b1; add_ready_i = 1'b1; mul_ready_i = 1'b1;
    add_req_valid_i = 1'b1; mul_req_valid_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      add_req_vect_i = (VW * W)'($urandom); mul_req_vect_i = (VW * W)'($urandom);
      step(1);
    end
    add_req_valid_i = 1'b0; mul_req_valid_i = 1'b0;
    step(6);
    check_eq("burst_seq_len", 64'(seq_q.size() >= 16), 64'(1));
    for (int i = 0; i < 16 && i < seq_q.size(); i++)
      check_eq($sformatf("burst_seq%0d", i), 64'(seq_q[i]), 64'((i / BL) % 2));

    // Credit limit with no results returned, then a single return.
    do_reset();
    add_ready_i = 1'b1; add_req_valid_i = 1'b1;
    step(8);
    check_eq("credit_beats", 64'(add_cyc_q.size()), 64'(MO));
    check_eq("credit_ready_low", 64'(add_req_ready_o), 64'(0));
    add_res_valid_i = 1'b1; add_res_ready_i = 1'b1;
    step(1);
    add_res_valid_i = 1'b0;
    check_eq("credit_reissue", 64'(add_valid_o), 64'(1));
    step(3);
    check_eq("credit_one_more", 64'(add_cyc_q.size()), 64'(MO + 1));
    add_req_valid_i = 1'b0; add_res_valid_i = 1'b1;
    step(MO + 1);
    add_res_valid_i = 1'b0;
    step(1);
    check_eq("credit_drained", 64'(add_outstanding_o), 64'(0));

    // Issue and return in the same cycle at count 2.
    do_reset();
    add_ready_i = 1'b1; add_req_valid_i = 1'b1;
    step(3);
    check_eq("same_pre", 64'(add_outstanding_o), 64'(2));
    add_res_valid_i = 1'b1; add_res_ready_i = 1'b1;
    step(1);
    add_res_valid_i = 1'b0; add_req_valid_i = 1'b0;
    check_eq("same_count", 64'(add_outstanding_o), 64'(2));
    step(2);

    // Clear while serving mul with 3 in flight.
    do_reset();
    mul_ready_i = 1'b1; mul_req_valid_i = 1'b1;
    step(4);
    check_eq("clr_pre_count", 64'(mul_outstanding_o), 64'(3));
    check_eq("clr_pre_op", 64'(operation_o), 64'(MUL));
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    check_eq("clr_state", 64'({busy_o, operation_o, add_outstanding_o, mul_outstanding_o}), 64'(0));
    check_eq("clr_valids", 64'({mul_valid_o, mul_req_ready_o, add_valid_o}), 64'(0));
    mul_req_valid_i = 1'b0;
    step(3);

    // Enable low for 3 cycles mid-burst: burst resumes where it stopped.
    do_reset();
    auto_ret = 1'b1; add_ready_i = 1'b1; mul_ready_i = 1'b1;
    s = cyc; add_req_valid_i = 1'b1; mul_req_valid_i = 1'b1;
    step(3);
    enable_i = 1'b0;
    step(3);
    check_eq("en_hold_beats", 64'(add_cyc_q.size() + mul_cyc_q.size()), 64'(2));
    check_eq("en_hold_op", 64'(operation_o), 64'(ADD));
    enable_i = 1'b1;
    step(6);
    add_req_valid_i = 1'b0; mul_req_valid_i = 1'b0;
    step(6);
    check_eq("en_add_beats", 64'(add_cyc_q.size()), 64'(4));
    if (add_cyc_q.size() == 4) begin
      check_eq("en_resume0", 64'(add_cyc_q[2]), 64'(s + 6));
      check_eq("en_resume1", 64'(add_cyc_q[3]), 64'(s + 7));
    end
    check_eq("en_mul_beats", 64'(mul_cyc_q.size()), 64'(4));
    if (mul_cyc_q.size() > 0) check_eq("en_mul_first", 64'(mul_cyc_q[0]), 64'(s + 8));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_i   = ($urandom_range(0, 299) == 0);
      clear_i = ($urandom_range(0, 149) == 0);
      enable_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 4) == 0) add_req_valid_i = !add_req_valid_i;
      if ($urandom_range(0, 4) == 0) mul_req_valid_i = !mul_req_valid_i;
      add_req_vect_i = (VW * W)'($urandom); mul_req_vect_i = (VW * W)'($urandom);
      add_req_strb_i = VW'($urandom); mul_req_strb_i = VW'($urandom);
      add_req_mod_i = 1'($urandom); mul_req_mod_i = 1'($urandom);
      add_ready_i = ($urandom_range(0, 4) != 0); mul_ready_i = ($urandom_range(0, 4) != 0);
      add_res_valid_i = ($urandom_range(0, 2) == 0); add_res_ready_i = ($urandom_range(0, 3) != 0);
      mul_res_valid_i = ($urandom_range(0, 2) == 0); mul_res_ready_i = ($urandom_range(0, 3) != 0);
      step(1);
    end
    rst_i = 1'b0;
    idle_inputs();
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
